// File: rtl/spi_cfg_pkg.sv
// Shared constants and state type for the SPI configuration-register write sequencer.
package spi_cfg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_UO  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_UIO = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_UO  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_UIO = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY   = 7'h04;
  localparam logic [6:0] ADDR_MAX        = 7'h04;

  localparam int FRAME_W   = 16;
  localparam int WRITE_BIT = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_cfg_controller_fifo.sv
// Synchronous request FIFO holding {addr, data} entries; one extra pointer bit
// distinguishes full from empty.
module spi_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/spi_cfg_controller.sv
// SPI mode-0 write sequencer for the configuration register bank.
// Optional SPI_CFG_SHADOW_EN suppresses writes that would not change a register.
module spi_cfg_controller
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_GAP     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       ncs,
  output logic       sclk,
  output logic       copi,
  output logic       busy,
  output logic       done,
  output logic       bad_addr
`ifdef SPI_CFG_SHADOW_EN
  ,
  output logic       skip
`endif
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [14:0]        head;
  state_t             state;
  logic [7:0]         cnt;
  logic               phase;
  logic [4:0]         bit_cnt;
  logic [FRAME_W-1:0] frame;
  logic               div_tc;
  logic               shadow_hit;

  assign req_ready = !full;
  assign push      = req_valid && !full && (req_addr <= ADDR_MAX);
  assign pop       = (state == ST_IDLE) && !empty;
  assign busy      = !empty || (state != ST_IDLE);
  assign div_tc    = (cnt == DIV_LAST);

  spi_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (15)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data ({req_addr, req_data}),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

`ifdef SPI_CFG_SHADOW_EN
  // Mirror of the peripheral's registers, committed only once a frame completes.
  logic [7:0] shadow [5];
  logic [2:0] cur_idx;
  logic [7:0] cur_data;

  assign shadow_hit = (shadow[head[10:8]] == head[7:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++)
        shadow[i] <= 8'h00;
      cur_idx  <= '0;
      cur_data <= '0;
    end else begin
      if (pop) begin
        cur_idx  <= head[10:8];
        cur_data <= head[7:0];
      end
      if (state == ST_GAP && cnt == 8'd0)
        shadow[cur_idx] <= cur_data;
    end
  end
`else
  assign shadow_hit = 1'b0;
`endif

  // Pin outputs are registered from the current state, so they trail the state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      frame    <= '0;
      ncs      <= 1'b1;
      sclk     <= 1'b0;
      copi     <= 1'b0;
      done     <= 1'b0;
      bad_addr <= 1'b0;
`ifdef SPI_CFG_SHADOW_EN
      skip     <= 1'b0;
`endif
    end else begin
      bad_addr <= req_valid && !full && (req_addr > ADDR_MAX);
      done     <= 1'b0;
      ncs      <= !(state == ST_SETUP || state == ST_SHIFT || state == ST_HOLD);
      sclk     <= (state == ST_SHIFT) && phase;
      copi     <= (state == ST_IDLE || state == ST_GAP) ? 1'b0 : frame[WRITE_BIT];
`ifdef SPI_CFG_SHADOW_EN
      skip     <= pop && shadow_hit;
`endif
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (pop && !shadow_hit) begin
            frame <= {1'b1, head};
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (div_tc) begin
            cnt     <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_SHIFT: begin
          if (div_tc) begin
            cnt <= '0;
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (bit_cnt == 5'd15) begin
                state <= ST_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                frame   <= {frame[FRAME_W-2:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          if (div_tc) begin
            cnt   <= '0;
            state <= ST_GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_GAP: begin
          done <= (cnt == 8'd0);
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Self-checking bench: directed plan steps plus randomized writes scored against
// a request-level model of accepted frames, bad addresses and shadow skips.
module tb_spi_cfg_controller;

  localparam int DIV0   = 4;
  localparam int DEPTH0 = 4;
  localparam int GAP0   = 2;
  localparam int DIV1   = 2;
  localparam int GAP1   = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid0, valid1;
  logic [6:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       ready0, ready1;
  logic       ncs0, ncs1, sclk0, sclk1, copi0, copi1;
  logic       busy0, busy1, done0, done1, bad0, bad1;
  logic [1:0] ncs_w, sclk_w, copi_w, done_w, bad_w, skip_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_cfg_controller #(.CLK_DIV(DIV0), .FIFO_DEPTH(DEPTH0), .CS_GAP(GAP0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(ready0),
    .req_addr(addr0), .req_data(data0), .ncs(ncs0), .sclk(sclk0), .copi(copi0),
    .busy(busy0), .done(done0), .bad_addr(bad0)
`ifdef SPI_CFG_SHADOW_EN
    , .skip(skip_w[0])
`endif
  );

  spi_cfg_controller #(.CLK_DIV(DIV1), .FIFO_DEPTH(2), .CS_GAP(GAP1)) dut_min (
    .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1),
    .req_addr(addr1), .req_data(data1), .ncs(ncs1), .sclk(sclk1), .copi(copi1),
    .busy(busy1), .done(done1), .bad_addr(bad1)
`ifdef SPI_CFG_SHADOW_EN
    , .skip(skip_w[1])
`endif
  );

`ifndef SPI_CFG_SHADOW_EN
  assign skip_w = 2'b00;
`endif
  assign ncs_w  = {ncs1, ncs0};
  assign sclk_w = {sclk1, sclk0};
  assign copi_w = {copi1, copi0};
  assign done_w = {done1, done0};
  assign bad_w  = {bad1, bad0};

  // Pin-level observer: reassembles frames from sclk rises while ncs is low.
  int          frames_n[2]  = '{0, 0};
  int          partial_n[2] = '{0, 0};
  int          done_n[2]    = '{0, 0};
  int          misalign_n[2] = '{0, 0};
  int          bad_n[2]     = '{0, 0};
  int          skip_n[2]    = '{0, 0};
  int          low_cnt[2]   = '{0, 0};
  int          high_cnt[2]  = '{0, 0};
  int          bits[2]      = '{0, 0};
  int          min_gap[2]   = '{1000, 1000};
  int          last_len[2]  = '{0, 0};
  logic [15:0] shreg[2];
  logic [15:0] last_frame[2];
  bit          seen[2]      = '{0, 0};
  logic [1:0]  prev_ncs     = 2'b11;
  logic [1:0]  prev_sclk    = 2'b00;
  logic [15:0] rx_q[$];
  int          len_q[$];

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (prev_ncs[k] && !ncs_w[k]) begin
          if (seen[k] && high_cnt[k] < min_gap[k]) min_gap[k] = high_cnt[k];
          bits[k] = 0; shreg[k] = 16'h0; low_cnt[k] = 0;
        end
        if (!prev_ncs[k] && ncs_w[k]) begin
          if (bits[k] == 16) begin
            frames_n[k]++;
            last_frame[k] = shreg[k];
            last_len[k]   = low_cnt[k];
            if (!done_w[k]) misalign_n[k]++;
            if (k == 0) begin
              rx_q.push_back(shreg[k]);
              len_q.push_back(low_cnt[k]);
            end
          end else begin
            partial_n[k]++;
          end
          seen[k] = 1'b1;
          high_cnt[k] = 0;
        end
        if (!ncs_w[k]) begin
          low_cnt[k]++;
          if (!prev_sclk[k] && sclk_w[k]) begin
            shreg[k] = {shreg[k][14:0], copi_w[k]};
            bits[k]++;
          end
        end else begin
          high_cnt[k]++;
        end
        if (done_w[k]) done_n[k]++;
        if (bad_w[k])  bad_n[k]++;
        if (skip_w[k]) skip_n[k]++;
        prev_ncs[k]  = ncs_w[k];
        prev_sclk[k] = sclk_w[k];
      end
    end
  end

  // Request-level reference: which writes reach the wire, in order.
  logic [15:0] exp_q[$];
  logic [7:0]  shadow_m[5];
  int          exp_bad  = 0;
  int          exp_skip = 0;

  function automatic void model_accept(input logic [6:0] a, input logic [7:0] d);
    if (a > 7'h04) begin
      exp_bad++;
    end else begin
`ifdef SPI_CFG_SHADOW_EN
      if (shadow_m[a[2:0]] == d) begin
        exp_skip++;
      end else begin
        exp_q.push_back({1'b1, a, d});
        shadow_m[a[2:0]] = d;
      end
`else
      exp_q.push_back({1'b1, a, d});
`endif
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) shadow_m[i] = 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [6:0] a, input logic [7:0] d, output bit stalled);
    int waited = 0;
    valid0 = 1'b1; addr0 = a; data0 = d;
    while (!ready0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    stalled = (waited > 0);
    check("send_ready", 32'(ready0), 32'd1);
    @(negedge clk);
    valid0 = 1'b0;
    model_accept(a, d);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy0 || !ncs0) && n < 5000);
    check({tag, "_idle_in_time"}, 32'(n < 5000), 32'd1);
    repeat (8) @(negedge clk);
  endtask

  task automatic compare_phase(input string tag);
    int m;
    check({tag, "_frame_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    m = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check({tag, "_frame_word"}, 32'(rx_q[i]), 32'(exp_q[i]));
      check({tag, "_ncs_low_len"}, 32'(len_q[i]), 32'(34 * DIV0));
    end
    check({tag, "_done_count"}, 32'(done_n[0]), 32'(frames_n[0]));
    check({tag, "_done_at_ncs_rise"}, 32'(misalign_n[0]), 32'd0);
    check({tag, "_bad_count"}, 32'(bad_n[0]), 32'(exp_bad));
`ifdef SPI_CFG_SHADOW_EN
    check({tag, "_skip_count"}, 32'(skip_n[0]), 32'(exp_skip));
`endif
    rx_q.delete();
    len_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit st;
    int stall_idx;
    int n;
    logic [6:0] ra;
    logic [7:0] rd;

    rst_n = 1'b0;
    valid0 = 1'b0; addr0 = '0; data0 = '0;
    valid1 = 1'b0; addr1 = '0; data1 = '0;
    model_reset();
    repeat (3) @(negedge clk);

    check("rst_ncs", 32'(ncs0), 32'd1);
    check("rst_sclk", 32'(sclk0), 32'd0);
    check("rst_copi", 32'(copi0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_bad", 32'(bad0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_ready", 32'(ready0), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single write 0x02=0xA5");
    send(7'h02, 8'hA5, st);
    check("lat_ncs_t0", 32'(ncs0), 32'd1);
    check("lat_busy_t0", 32'(busy0), 32'd1);
    @(negedge clk);
    check("lat_ncs_t1", 32'(ncs0), 32'd1);
    @(negedge clk);
    check("lat_ncs_t2", 32'(ncs0), 32'd0);
    wait_idle("single");
    check("single_word", 32'(last_frame[0]), 32'h82A5);
    check("single_len", 32'(last_len[0]), 32'd136);
    check("single_busy", 32'(busy0), 32'd0);
    compare_phase("single");

    $display("[TB] bad address 0x05");
    send(7'h05, 8'hFF, st);
    check("bad_pulse", 32'(bad0), 32'd1);
    @(negedge clk);
    check("bad_pulse_end", 32'(bad0), 32'd0);
    check("bad_ncs", 32'(ncs0), 32'd1);
    check("bad_busy", 32'(busy0), 32'd0);
    repeat (5) @(negedge clk);
    compare_phase("bad");

    $display("[TB] burst of six");
    stall_idx = -1;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) send(7'(i), 8'(8'h11 * (i + 1)), st);
      else       send(7'h00, 8'h3C, st);
      if (st && stall_idx < 0) stall_idx = i;
    end
    check("burst_stall_idx", 32'(stall_idx), 32'(DEPTH0 + 1));
    wait_idle("burst");
    compare_phase("burst");
    check("burst_min_gap", 32'(min_gap[0] >= GAP0), 32'd1);

    $display("[TB] reset mid-frame");
    send(7'h03, 8'h11, st);
    send(7'h04, 8'h22, st);
    send(7'h01, 8'h33, st);
    n = 0;
    while (bits[0] != 8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rmf_reach_bit8", 32'(bits[0]), 32'd8);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rmf_ncs", 32'(ncs0), 32'd1);
    check("rmf_sclk", 32'(sclk0), 32'd0);
    check("rmf_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (300) @(negedge clk);
    check("rmf_no_frame", 32'(rx_q.size()), 32'd0);
    check("rmf_partial", 32'(partial_n[0]), 32'd1);
    check("rmf_idle", 32'(busy0), 32'd0);

    $display("[TB] shadow stimulus");
    send(7'h04, 8'h80, st);
    send(7'h04, 8'h80, st);
    send(7'h00, 8'h00, st);
    wait_idle("shadow");
`ifdef SPI_CFG_SHADOW_EN
    check("shadow_frames", 32'(rx_q.size()), 32'd1);
    check("shadow_skips", 32'(skip_n[0]), 32'd2);
`else
    check("shadow_frames", 32'(rx_q.size()), 32'd3);
`endif
    compare_phase("shadow");

    $display("[TB] minimum divider 0x01=0x5A");
    valid1 = 1'b1; addr1 = 7'h01; data1 = 8'h5A;
    @(negedge clk);
    valid1 = 1'b0;
    n = 0;
    while (frames_n[1] < 1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("min_frames", 32'(frames_n[1]), 32'd1);
    check("min_word", 32'(last_frame[1]), 32'h815A);
    check("min_len", 32'(last_len[1]), 32'd68);
    check("min_done", 32'(done_n[1]), 32'd1);
    check("min_busy", 32'(busy1), 32'd0);

    $display("[TB] randomized writes");
    for (int i = 0; i < 24; i++) begin
      ra = 7'($urandom_range(0, 6));
      rd = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(ra, rd, st);
    end
    wait_idle("rand");
    compare_phase("rand");
    check("rand_min_gap", 32'(min_gap[0] >= GAP0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
